// File: rtl/icache_lookup_ctrl_pkg.sv
// Shared geometry, bit positions and FSM encoding for the instruction-cache lookup/refill path.
package icache_lookup_ctrl_pkg;

  localparam int unsigned SetNum      = 64;
  localparam int unsigned SetBits     = 6;
  localparam int unsigned LineWords   = 4;
  localparam int unsigned TagBits     = 22;
  localparam int unsigned WordLsb     = 2;
  localparam int unsigned IdxLsb      = 4;
  localparam int unsigned TagLsb      = 10;
  localparam int unsigned TagValidBit = 31;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLookup = 3'd1,
    StMiss   = 3'd2,
    StRefill = 3'd3,
    StFill   = 3'd4
  } state_e;

endpackage

// File: rtl/icache_refill_buf.sv
// Refill line buffer: beat counter plus line storage; line_o shows the buffer with the
// current beat already merged in.
module icache_refill_buf
  import icache_lookup_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LineWords
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    beat_valid_i,
  input  logic [31:0]             beat_data_i,
  output logic [LINE_WORDS*32-1:0] line_o
);

  localparam int unsigned CntW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      // Words never delivered by a short burst must read back as zero.
      cnt_d  = '0;
      line_d = '0;
    end else if (beat_valid_i) begin
      line_d[cnt_q] = beat_data_i;
      cnt_d         = (cnt_q == CntW'(LINE_WORDS - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_o = line_d;

endmodule

// File: rtl/icache_lookup_ctrl.sv
// Direct-mapped I-cache lookup/refill controller. Define ICACHE_PERF_CNT_EN to add the
// hit_cnt/miss_cnt performance counter outputs.
module icache_lookup_ctrl
  import icache_lookup_ctrl_pkg::*;
#(
  parameter int unsigned SET_BITS   = 6,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_BITS   = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [31:0]              resp_data,
  output logic [SET_BITS-1:0]      tag_addrb,
  input  logic [31:0]              tag_doutb,
  output logic [3:0]               tag_wea,
  output logic [SET_BITS-1:0]      tag_addra,
  output logic [31:0]              tag_dina,
  output logic [SET_BITS-1:0]      data_addr,
  input  logic [LINE_WORDS*32-1:0] data_rdata,
  output logic                     data_we,
  output logic [LINE_WORDS*32-1:0] data_wdata,
  output logic                     mem_rd_req,
  output logic [31:0]              mem_rd_addr,
  input  logic                     mem_rd_ready,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rlast
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
`endif
);

  localparam int unsigned WordBits = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LineIdx  = WordLsb + WordBits;
  localparam int unsigned TagIdx   = LineIdx + SET_BITS;

  state_e                      state_q, state_d;
  logic [31:0]                 cap_addr_q;
  logic [SET_BITS-1:0]         cap_index;
  logic [TAG_BITS-1:0]         cap_tag;
  logic [WordBits-1:0]         cap_word;
  logic                        accept;
  logic                        hit;
  logic                        buf_clear;
  logic                        beat_valid;
  logic [LINE_WORDS*32-1:0]    buf_line_flat;
  logic [LINE_WORDS-1:0][31:0] buf_line;
  logic [LINE_WORDS-1:0][31:0] rd_line;
  logic                        unused_bits;

  assign cap_index = cap_addr_q[TagIdx-1:LineIdx];
  assign cap_tag   = cap_addr_q[TagIdx+TAG_BITS-1:TagIdx];
  assign cap_word  = cap_addr_q[LineIdx-1:WordLsb];
  assign rd_line   = data_rdata;
  assign buf_line  = buf_line_flat;
  assign accept    = req_valid & req_ready;
  assign hit       = tag_doutb[TagValidBit] & (tag_doutb[TAG_BITS-1:0] == cap_tag);

  assign unused_bits = ^{cap_addr_q[WordLsb-1:0], tag_doutb[TagValidBit-1:TAG_BITS]};

  // RAM read ports follow the incoming request so the registered tag is ready next cycle.
  assign tag_addrb = req_ready ? req_addr[TagIdx-1:LineIdx] : cap_index;
  assign data_addr = tag_addrb;

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    tag_wea     = '0;
    tag_addra   = '0;
    tag_dina    = '0;
    data_we     = 1'b0;
    data_wdata  = '0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    buf_clear   = 1'b0;
    beat_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_data  = rd_line[cap_word];
          req_ready  = 1'b1;
          state_d    = req_valid ? StLookup : StIdle;
        end else begin
          state_d = StMiss;
        end
      end
      StMiss: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {cap_addr_q[31:LineIdx], {LineIdx{1'b0}}};
        if (mem_rd_ready) begin
          buf_clear = 1'b1;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        beat_valid = mem_rvalid;
        if (mem_rvalid && mem_rlast) state_d = StFill;
      end
      StFill: begin
        tag_wea    = '1;
        tag_addra  = cap_index;
        tag_dina   = {1'b1, {(31 - TAG_BITS){1'b0}}, cap_tag};
        data_we    = 1'b1;
        data_wdata = buf_line_flat;
        // Critical word comes from the buffer; the data RAM is not re-read.
        resp_valid = 1'b1;
        resp_data  = buf_line[cap_word];
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cap_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cap_addr_q <= req_addr;
    end
  end

  icache_refill_buf #(
    .LINE_WORDS(LINE_WORDS)
  ) u_refill_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (buf_clear),
    .beat_valid_i(beat_valid),
    .beat_data_i (mem_rdata),
    .line_o      (buf_line_flat)
  );

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == StLookup) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_lookup_ctrl.sv
// Scoreboard bench for icache_lookup_ctrl with tag/data RAM and line-memory models.
module tb_icache_lookup_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic [5:0]   tag_addrb;
  logic [31:0]  tag_doutb;
  logic [3:0]   tag_wea;
  logic [5:0]   tag_addra;
  logic [31:0]  tag_dina;
  logic [5:0]   data_addr;
  logic [127:0] data_rdata;
  logic         data_we;
  logic [127:0] data_wdata;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         mem_rlast;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_lookup_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .tag_addrb   (tag_addrb),
    .tag_doutb   (tag_doutb),
    .tag_wea     (tag_wea),
    .tag_addra   (tag_addra),
    .tag_dina    (tag_dina),
    .data_addr   (data_addr),
    .data_rdata  (data_rdata),
    .data_we     (data_we),
    .data_wdata  (data_wdata),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_ready(mem_rd_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rlast   (mem_rlast)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0]  addr;
    logic         hit;
    logic [31:0]  data;
    logic [127:0] line;
    int           acc_cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [31:0]  tag_mem [64];
  logic [127:0] data_mem [64];
  logic         ref_valid [64];
  logic [21:0]  ref_tag [64];
  logic [127:0] ref_line [64];
  int           exp_hits = 0;
  int           exp_misses = 0;
  int           total_misses = 0;
  int           mem_reqs = 0;
  logic [31:0]  last_miss_line = '0;
  bit           rand_mode = 0;
  int           mem_stall_fixed = 0;
  int           early_last = 0;
  int           extra_beats = 0;
  int           abort_beats = 0;
  bit           abort_done = 0;
  bit           paused = 0;
  bit           mem_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Tag RAM: registered read, output register cleared by its reset (rst_n = ~rst).
  always @(posedge clk or posedge rst) begin
    if (rst) tag_doutb <= '0;
    else begin
      if (tag_wea == 4'hF) tag_mem[tag_addra] <= tag_dina;
      tag_doutb <= tag_mem[tag_addrb];
    end
  end

  always @(posedge clk) begin
    if (data_we) data_mem[data_addr] <= data_wdata;
    data_rdata <= data_mem[data_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] la, input int w);
    if (la == 32'h0000_1230) return 32'hA0 + 32'(w);
    return (la * 32'h9E37_79B1) ^ (32'(w) << 28) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la, input int nb);
    logic [127:0] l = '0;
    for (int w = 0; w < 4; w++) if (w < nb) l[w*32 +: 32] = mem_word(la, w);
    return l;
  endfunction

  // Reference cache: a request hits iff its set holds its tag; a miss installs the line
  // exactly as memory delivers it.
  task automatic push(input logic [31:0] a);
    exp_t e;
    int   idx = int'(a[9:4]);
    int   w   = int'(a[3:2]);
    e.addr    = a;
    e.acc_cyc = cyc;
    if (ref_valid[idx] && ref_tag[idx] == a[31:10]) begin
      e.hit  = 1'b1;
      e.line = ref_line[idx];
      exp_hits++;
    end else begin
      e.hit          = 1'b0;
      e.line         = mem_line({a[31:4], 4'b0}, (early_last > 0) ? early_last : 4);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[31:10];
      ref_line[idx]  = e.line;
      last_miss_line = {a[31:4], 4'b0};
      exp_misses++;
      total_misses++;
    end
    e.data = e.line[w*32 +: 32];
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: addr %h not accepted, req_ready %b required 1", a, req_ready);
      req_valid = 1'b0;
    end else begin
      push(a);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while ((q.size() != 0 || mem_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || mem_busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (resp_valid) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got data %h, required no response", resp_data);
          end else begin
            e = q.pop_front();
            chk("resp_data", resp_data, e.data);
            if (e.hit) begin
              chk("hit_latency", cyc, e.acc_cyc + 1);
              chk("hit_no_write", {tag_wea, data_we}, 5'b0);
            end else begin
              chk("fill_tag_wea", tag_wea, 4'hF);
              chk("fill_tag_addra", tag_addra, e.addr[9:4]);
              chk("fill_tag_dina", tag_dina, {1'b1, 9'b0, e.addr[31:10]});
              chk("fill_data_we", data_we, 1'b1);
              chk("fill_data_addr", data_addr, e.addr[9:4]);
              chk("fill_line", data_wdata, e.line);
            end
          end
        end else begin
          chk("idle_no_write", {tag_wea, data_we}, 5'b0);
        end
      end
    end
  end

  // Line memory responder.
  initial begin
    logic [31:0] line;
    int          stall;
    int          nb;
    int          n;
    mem_rd_ready = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    mem_rlast    = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_req && !rst) begin
        mem_busy = 1'b1;
        mem_reqs++;
        line = mem_rd_addr;
        chk("mem_rd_addr", line, last_miss_line);
        stall = rand_mode ? int'($urandom_range(0, 3)) : mem_stall_fixed;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_req_hold", mem_rd_req, 1'b1);
          chk("stall_addr_hold", mem_rd_addr, line);
          chk("stall_no_resp", resp_valid, 1'b0);
        end
        mem_rd_ready = 1'b1;
        @(negedge clk);
        mem_rd_ready = 1'b0;
        nb = (early_last > 0) ? early_last : 4;
        for (int b = 0; b < nb + extra_beats; b++) begin
          if (rand_mode) repeat ($urandom_range(0, 2)) @(negedge clk);
          mem_rvalid = 1'b1;
          mem_rdata  = (b < nb) ? mem_word(line, b) : ~mem_word(line, b);
          mem_rlast  = (b == nb - 1);
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rlast  = 1'b0;
          if (abort_beats != 0 && b + 1 == abort_beats) begin
            paused = 1'b1;
            n = 0;
            while (!abort_done && n < 100) begin
              @(negedge clk);
              n++;
            end
            paused = 1'b0;
          end
        end
        mem_busy = 1'b0;
      end
    end
  end

  initial begin
    int c0;
    int n;
    logic [31:0] a;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    for (int i = 0; i < 64; i++) begin
      tag_mem[i]   = '0;
      data_mem[i]  = '0;
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
      ref_line[i]  = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_rd_req", mem_rd_req, 1'b0);
    chk("rst_writes", {tag_wea, data_we}, 5'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, then same-line request accepted as soon as the fill retires.
    issue(32'h0000_1234);
    issue(32'h0000_1238);
    drain();
    chk("tag_ram_23", tag_mem[6'h23], 32'h8000_0004);

    // Back-to-back hits: one accept per cycle.
    c0 = cyc;
    issue(32'h0000_1230);
    issue(32'h0000_1234);
    issue(32'h0000_1238);
    issue(32'h0000_123C);
    req_valid = 1'b0;
    chk("b2b_accept_cycles", cyc - c0, 4);
    drain();

    // Conflict miss evicts tag 4, so tag 4 misses again afterwards.
    issue(32'h0000_1634);
    drain();
    chk("tag_ram_conflict", tag_mem[6'h23], 32'h8000_0005);
    issue(32'h0000_1234);
    drain();

    // Memory holds off the request for 5 cycles.
    mem_stall_fixed = 5;
    issue(32'h0000_2248);
    drain();
    mem_stall_fixed = 0;

    // Short burst: words 2 and 3 stay zero.
    early_last = 2;
    issue(32'h0000_3358);
    drain();
    early_last = 0;
    issue(32'h0000_3354);
    drain();

    // Beats after rlast are ignored.
    extra_beats = 2;
    issue(32'h0000_4460);
    drain();
    extra_beats = 0;
    issue(32'h0000_446C);
    drain();

    rand_mode = 1;
    for (int i = 0; i < 200; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      issue(a);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();
    rand_mode = 0;

    // Asynchronous reset after the second refill beat.
    abort_beats = 2;
    abort_done  = 0;
    issue(32'h0000_03F4);
    req_valid = 1'b0;
    n = 0;
    #1;
    while (!paused && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_point_reached", paused, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_mem_rd_req", mem_rd_req, 1'b0);
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_writes", {tag_wea, data_we}, 5'b0);
    chk("abort_resp_valid", resp_valid, 1'b0);
    q.delete();
    ref_valid[6'h3F] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    rst         = 1'b0;
    abort_done  = 1;
    abort_beats = 0;
    drain();
    chk("abort_no_tag_write", tag_mem[6'h3F], 32'h0);
    issue(32'h0000_03F4);
    drain();

    chk("mem_req_count", mem_reqs, total_misses);
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, 32'(exp_hits));
    chk("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
